// File: rtl/lcd_text_pkg.sv
// Shared constants, state encoding and character helper for the LCD text buffer.
package lcd_text_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned CHAR_ADDR_W       = 7;
  localparam int unsigned NUM_CHARS_DEFAULT = 32;

  localparam logic [BYTE_W-1:0] STX      = 8'h02;
  localparam logic [BYTE_W-1:0] ETX      = 8'h03;
  localparam logic [BYTE_W-1:0] PAD_CHAR = 8'h20;
  localparam logic [BYTE_W-1:0] SUB_CHAR = 8'h3F;

  localparam logic [3:0] ST_IDLE_ENC = 4'b0001;
  localparam logic [3:0] ST_RECV_ENC = 4'b0010;
  localparam logic [3:0] ST_FILL_ENC = 4'b0100;
  localparam logic [3:0] ST_HOLD_ENC = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_RECV = ST_RECV_ENC,
    ST_FILL = ST_FILL_ENC,
    ST_HOLD = ST_HOLD_ENC
  } state_t;

  // Printable ASCII passes through; anything else shows as '?'.
  function automatic logic [BYTE_W-1:0] sanitize_char(input logic [BYTE_W-1:0] b);
    return ((b >= 8'h20) && (b <= 8'h7E)) ? b : SUB_CHAR;
  endfunction

endpackage

// File: rtl/lcd_text_ram.sv
// Double-banked character store: writes go to bank ~sel, registered reads come from bank sel.
module lcd_text_ram
  import lcd_text_pkg::*;
#(
  parameter int unsigned NUM_CHARS = NUM_CHARS_DEFAULT,
  parameter int unsigned ADDR_W    = $clog2(NUM_CHARS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [BYTE_W-1:0]      wr_data,
  input  logic [CHAR_ADDR_W-1:0] rd_addr,
  output logic [BYTE_W-1:0]      rd_data,
  input  logic                   sel_toggle
);

  logic [BYTE_W-1:0] bank0 [NUM_CHARS];
  logic [BYTE_W-1:0] bank1 [NUM_CHARS];
  logic              sel_q;
  logic [ADDR_W-1:0] rd_idx;

  assign rd_idx = rd_addr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q <= 1'b0;
    end else if (sel_toggle) begin
      sel_q <= ~sel_q;
    end
  end

  // A write in the swap cycle still lands in the outgoing write bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_CHARS); i++) begin
        bank0[i] <= PAD_CHAR;
        bank1[i] <= PAD_CHAR;
      end
    end else if (wr_en) begin
      if (sel_q) begin
        bank0[wr_addr] <= wr_data;
      end else begin
        bank1[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= PAD_CHAR;
    end else if (32'(rd_addr) < NUM_CHARS) begin
      rd_data <= sel_q ? bank1[rd_idx] : bank0[rd_idx];
    end else begin
      rd_data <= PAD_CHAR;
    end
  end

endmodule

// File: rtl/lcd_text_buffer.sv
// Frames an STX/ETX byte stream into a padded text page and hands it to the LCD via a bank swap.
module lcd_text_buffer
  import lcd_text_pkg::*;
#(
  parameter int unsigned NUM_CHARS   = NUM_CHARS_DEFAULT,
  parameter int unsigned UPDATE_HOLD = 200000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [BYTE_W-1:0]      rx_data,
  input  logic [CHAR_ADDR_W-1:0] char_address,
  output logic [BYTE_W-1:0]      lcd_data,
  output logic                   update,
  output logic                   busy,
  output logic                   overflow
);

  localparam int unsigned ADDR_W = $clog2(NUM_CHARS);
  localparam int unsigned PTR_W  = $clog2(NUM_CHARS + 1);
  localparam int unsigned CNT_W  = $clog2(UPDATE_HOLD + 1);

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_d, upd_d, busy_d;
  logic                wr_en_c, swap_c;
  logic [BYTE_W-1:0]   wr_data_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q    <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
      update   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      overflow <= ovf_d;
      update   <= upd_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = overflow;
    upd_d     = update;
    wr_en_c   = 1'b0;
    wr_data_c = PAD_CHAR;
    swap_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == STX)) begin
          ptr_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          if (rx_data == STX) begin
            ptr_d = '0;
            ovf_d = 1'b0;
          end else if (rx_data == ETX) begin
            state_d = ST_FILL;
          end else if (ptr_q < PTR_W'(NUM_CHARS)) begin
            wr_en_c   = 1'b1;
            wr_data_c = sanitize_char(rx_data);
            ptr_d     = ptr_q + PTR_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      // Last pad write and swap share a cycle; a full frame swaps on its first FILL cycle.
      ST_FILL: begin
        if (ptr_q < PTR_W'(NUM_CHARS)) begin
          wr_en_c = 1'b1;
          ptr_d   = ptr_q + PTR_W'(1);
        end
        if (ptr_q >= PTR_W'(NUM_CHARS - 1)) begin
          swap_c  = 1'b1;
          upd_d   = 1'b0;
          cnt_d   = CNT_W'(UPDATE_HOLD);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q <= CNT_W'(1)) begin
          upd_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_FILL) || (state_d == ST_HOLD);
  end

  lcd_text_ram #(
    .NUM_CHARS (NUM_CHARS),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en_c),
    .wr_addr    (ptr_q[ADDR_W-1:0]),
    .wr_data    (wr_data_c),
    .rd_addr    (char_address),
    .rd_data    (lcd_data),
    .sel_toggle (swap_c)
  );

endmodule

// File: doc/lcd_text_buffer.md
LCD_TEXT_BUFFER -- requirements
Module: lcd_text_buffer

Interface
REQ-001 The module SHALL declare parameter NUM_CHARS, default 32: number of display character cells (2 rows x 16).
REQ-002 The module SHALL declare parameter UPDATE_HOLD, default 200000: clk cycles that update is held low. The default exceeds one LCD internal tick of 160004 clk.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port rx_valid, input, 1 bit: rx_data is valid this cycle, one byte per cycle max.
REQ-006 The module SHALL have port rx_data, input, 8 bits: byte from the upstream SPI/DSP stream.
REQ-007 The module SHALL have port char_address, input, 7 bits: character index requested by the LCD controller.
REQ-008 The module SHALL have port lcd_data, output, 8 bits: character code for char_address, which feeds the LCD controller's lcd_data_in.
REQ-009 The module SHALL have port update, output, 1 bit: active-low refresh request to the LCD controller.
REQ-010 The module SHALL have port busy, output, 1 bit: high in FILL or HOLD, when incoming bytes are dropped.
REQ-011 The module SHALL have port overflow, output, 1 bit: sticky flag, set when a frame exceeded NUM_CHARS.

Function
REQ-012 Frame format SHALL be STX (8'h02), then 0..N payload bytes, then ETX (8'h03).
REQ-013 Storage SHALL be two banks of NUM_CHARS x 8: a display bank (read by the LCD) and a write bank (being filled).
REQ-014 The FSM SHALL have states IDLE, RECV, FILL, HOLD, encoded one-hot.
REQ-015 In IDLE, STX SHALL clear write_ptr and overflow and go to RECV; all other bytes SHALL be ignored.
REQ-016 In RECV, a payload byte with write_ptr < NUM_CHARS SHALL be written to write bank[write_ptr], and write_ptr SHALL increment.
REQ-017 Payload bytes outside 8'h20..8'h7E SHALL be stored as 8'h3F ('?'), except STX and ETX.
REQ-018 In RECV, a payload byte with write_ptr == NUM_CHARS SHALL be dropped and SHALL set overflow.
REQ-019 In RECV, STX SHALL restart the frame: write_ptr <= 0, overflow <= 0, stay in RECV.
REQ-020 In RECV, ETX SHALL go to FILL.
REQ-021 In FILL, the block SHALL write 8'h20 to write bank[write_ptr] and increment write_ptr, one cell per cycle, while write_ptr < NUM_CHARS.
REQ-022 On reaching NUM_CHARS, the block SHALL swap banks in the same cycle, drive update low, load the hold counter, and go to HOLD.
REQ-023 An ETX received with write_ptr == NUM_CHARS SHALL swap on the cycle after ETX. FILL latency SHALL be (NUM_CHARS - write_ptr) cycles, minimum 1.
REQ-024 In HOLD, update SHALL stay low for exactly UPDATE_HOLD cycles, then go high, and the FSM SHALL return to IDLE.
REQ-025 rx_valid in FILL or HOLD SHALL be dropped without effect on overflow.
REQ-026 lcd_data SHALL be registered with 1-cycle latency: lcd_data <= display bank[char_address].
REQ-027 char_address >= NUM_CHARS SHALL return 8'h20.
REQ-028 The display bank SHALL change only at the swap cycle; it SHALL never be written directly.
REQ-029 rx_valid low SHALL cause no state change, except the FILL and HOLD progression.

Reset
REQ-030 Reset low SHALL asynchronously force the following values.
- FSM: IDLE.
- Counters: write_ptr = 0, hold counter = 0.
- Banks: bank select = 0, all cells of both banks = 8'h20.
- Outputs: update = 1, busy = 0, overflow = 0, lcd_data = 8'h20.
REQ-031 Reset asserted mid-frame or during HOLD SHALL abandon the frame and release update high immediately; no swap SHALL occur.

Structure
REQ-032 Package lcd_text_pkg SHALL hold the following.
- Constants: STX, ETX, PAD_CHAR (8'h20), SUB_CHAR (8'h3F), NUM_CHARS default.
- State encoding constants.
REQ-033 Sub-module lcd_text_ram SHALL implement the two banks. It SHALL have one write port (bank = ~sel), one registered read port (bank = sel), a sel toggle input, and asynchronous reset to PAD_CHAR.

Verification
REQ-034 Bench SHALL run these directed scenarios, all with UPDATE_HOLD = 8.
- 02 'H' 'I' 03: FILL 30 cycles, then swap. Addresses 0,1 read 0x48,0x49; addresses 2..31 read 0x20. update low exactly 8 cycles.
- 02, 40 x 'A', 03: overflow = 1; addresses 0..31 read 0x41; only one update pulse.
- 02, 0x07, 0x7F, 'Z', 03: addresses 0,1,2 read 0x3F,0x3F,0x5A.
- 02 'A' 02 'B' 03: address 0 reads 0x42; address 1 reads 0x20.
- Frame sent during HOLD: busy = 1; bytes dropped; display unchanged; no second update pulse.
- Reset pulsed mid-RECV after 5 bytes: update = 1; all reads return 0x20; FSM in IDLE; a subsequent full frame displays correctly.
